// File: rtl/vga_overlay_regs.sv
// ============================================================================
// Module   : vga_overlay_regs
// Purpose  : Field register bank, cursor blink highlight and PS/2 arrow overlay.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module vga_overlay_regs #(
  parameter int             NUM_FIELDS  = 9,
  parameter logic [7:0]     PORT_BASE   = 8'h02,
  parameter logic [7:0]     PTR_PORT    = 8'h0E,
  parameter int             SEL_OFFSET  = 2,
  parameter logic [11:0]    HL_COLOR    = 12'hF00,
  parameter logic [11:0]    BG_COLOR    = 12'h000,
  parameter logic [11:0]    FG_COLOR    = 12'hFFF,
  parameter int             BLINK_W     = 24,
  parameter bit             BLINK_EN    = 1'b1,
  parameter logic [159:0]   ARROW_RECTS = {
    10'd480, 10'd520, 10'd60,  10'd100,   // up
    10'd480, 10'd520, 10'd120, 10'd160,   // down
    10'd530, 10'd570, 10'd90,  10'd130,   // right
    10'd430, 10'd470, 10'd90,  10'd130    // left
  }
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    WRITE_STROBE,
  input  logic [7:0]              POR_ID,
  input  logic [7:0]              OUT_PORT,
  input  logic                    KEY_STROBE,
  input  logic [7:0]              KEY_CODE,
  input  logic [9:0]              ADDRH,
  input  logic [9:0]              ADDRV,
  input  logic [4:0]              SELECTOR,
  input  logic [11:0]             COLOR_IN,
  output logic [8*NUM_FIELDS-1:0] FIELDS_OUT,
  output logic [7:0]              POINTER,
  output logic [3:0]              KEY_HELD,
  output logic [11:0]             RGB
);

  localparam logic [7:0] c_num_fields = 8'(NUM_FIELDS);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BREAK = 1'b1;

  logic [7:0]         r_ptr;
  logic [BLINK_W-1:0] r_blink;
  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [3:0]         r_held;
  logic [3:0]         w_held_nxt;
  logic [3:0]         w_key_arrow;
  logic [3:0]         w_in_rect;
  logic               w_ptr_wr;
  logic               w_ptr_valid;
  logic [8:0]         w_sel_lo;
  logic [8:0]         w_sel;
  logic               w_cursor_hit;
  logic               w_arrow_hit;
  logic               w_blink_on;
  logic [11:0]        r_rgb;

  assign w_ptr_wr = WRITE_STROBE && (POR_ID == PTR_PORT);

  // ---------------------------------------------------------------- fields
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_field
    logic [7:0] r_field;
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
        r_field <= 8'h00;
      else if (WRITE_STROBE && (POR_ID == 8'(PORT_BASE + i)))
        r_field <= OUT_PORT;
    end
    assign FIELDS_OUT[8*i +: 8] = r_field;
  end

  // Pointer write restarts the blink so the new cursor shows at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_ptr   <= 8'h00;
      r_blink <= '0;
    end else begin
      if (w_ptr_wr)
        r_ptr <= OUT_PORT;
      if (w_ptr_wr)
        r_blink <= '0;
      else
        r_blink <= r_blink + 1'b1;
    end
  end

  // ---------------------------------------------------------------- key FSM
  always_comb begin
    w_key_arrow = 4'b0000;
    case (KEY_CODE)
      8'h75:   w_key_arrow = 4'b1000;
      8'h72:   w_key_arrow = 4'b0100;
      8'h74:   w_key_arrow = 4'b0010;
      8'h6B:   w_key_arrow = 4'b0001;
      default: w_key_arrow = 4'b0000;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_held  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (KEY_STROBE) begin
      case (r_state)
        S_IDLE:  w_state_nxt = (KEY_CODE == 8'hF0) ? S_BREAK : S_IDLE;
        S_BREAK: w_state_nxt = (KEY_CODE == 8'hE0) ? S_BREAK : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_held_nxt = r_held;
    if (KEY_STROBE) begin
      if (r_state == S_IDLE)
        w_held_nxt = r_held | w_key_arrow;
      else
        w_held_nxt = r_held & ~w_key_arrow;
    end
  end

  // ---------------------------------------------------------------- pixel path
  for (genvar j = 0; j < 4; j++) begin : g_rect
    assign w_in_rect[j] = (ADDRH >= ARROW_RECTS[40*j+30 +: 10]) &&
                          (ADDRH <= ARROW_RECTS[40*j+20 +: 10]) &&
                          (ADDRV >= ARROW_RECTS[40*j+10 +: 10]) &&
                          (ADDRV <= ARROW_RECTS[40*j    +: 10]);
  end

  assign w_arrow_hit  = (|(w_in_rect & r_held)) && (COLOR_IN == FG_COLOR);
  assign w_ptr_valid  = (r_ptr != 8'h00) && (r_ptr <= c_num_fields);
  // Pointer k selects field k-1, whose first digit is SEL_OFFSET + 2(k-1).
  assign w_sel_lo     = 9'(SEL_OFFSET) + {r_ptr, 1'b0} - 9'd2;
  assign w_sel        = {4'b0000, SELECTOR};
  assign w_blink_on   = !BLINK_EN || !r_blink[BLINK_W-1];
  assign w_cursor_hit = w_ptr_valid && w_blink_on && (COLOR_IN != BG_COLOR) &&
                        ((w_sel == w_sel_lo) || (w_sel == w_sel_lo + 9'd1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      r_rgb <= 12'h000;
    else if (w_arrow_hit || w_cursor_hit)
      r_rgb <= HL_COLOR;
    else
      r_rgb <= COLOR_IN;
  end

  assign POINTER  = r_ptr;
  assign KEY_HELD = r_held;
  assign RGB      = r_rgb;

endmodule

`default_nettype wire
